counter_seg_display: RTL and testbench



---
 rtl/counter_seg_display.sv | 160 ++++++++++++++++
 tb/tb_counter_seg_display.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_seg_display.sv
// counter_seg_display: samples a 0..30 counter, converts it to two BCD digits
// and scans a two-digit 7-segment display. Flags wrap events and value 31.
module counter_seg_display #(
  parameter int unsigned SCAN_DIV       = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] counter,
  input  logic       mode,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] dig_en,
  output logic       wrap,
  output logic       err
);
  typedef enum logic {SCAN_ONES = 1'b0, SCAN_TENS = 1'b1} scan_t;

  localparam logic [15:0] PRESC_TC = 16'(SCAN_DIV - 1);
  localparam logic [6:0]  SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic        DP_OFF   = SEG_ACTIVE_LOW;

  logic [4:0]  r_cnt, r_prev;
  logic        r_mode, r_smp_v, r_hist_v;
  logic [3:0]  r_tens, r_ones;
  logic        r_mode_d;
  scan_t       r_state, w_state_nxt;
  logic [15:0] r_presc, w_presc_nxt;
  logic [3:0]  w_tens, w_ones;
  logic [6:0]  w_seg_nxt;
  logic        w_dp_nxt;
  logic [1:0]  w_dig_nxt;
  logic        w_wrap_evt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      4'hF:    seg_decode = 7'h40;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  // Stage 1: sample counter/mode; hist_v marks prev_q as holding a real sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 5'd0;
      r_mode   <= 1'b0;
      r_prev   <= 5'd0;
      r_smp_v  <= 1'b0;
      r_hist_v <= 1'b0;
    end else begin
      r_cnt    <= counter;
      r_mode   <= mode;
      r_prev   <= r_cnt;
      r_smp_v  <= 1'b1;
      r_hist_v <= r_smp_v;
    end
  end

  // Binary to BCD; 31 maps to the dash code on both digits
  always_comb begin
    w_tens = 4'd0;
    w_ones = 4'(r_cnt);
    if (r_cnt == 5'd31) begin
      w_tens = 4'hF;
      w_ones = 4'hF;
    end else if (r_cnt >= 5'd30) begin
      w_tens = 4'd3;
      w_ones = 4'(r_cnt - 5'd30);
    end else if (r_cnt >= 5'd20) begin
      w_tens = 4'd2;
      w_ones = 4'(r_cnt - 5'd20);
    end else if (r_cnt >= 5'd10) begin
      w_tens = 4'd1;
      w_ones = 4'(r_cnt - 5'd10);
    end
  end

  assign w_wrap_evt = r_hist_v &&
                      (((r_prev == 5'd30) && (r_cnt == 5'd0)) ||
                       ((r_prev == 5'd0)  && (r_cnt == 5'd30)));

  // Stage 2: digit registers plus wrap pulse and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tens   <= 4'd0;
      r_ones   <= 4'd0;
      r_mode_d <= 1'b0;
      wrap     <= 1'b0;
      err      <= 1'b0;
    end else begin
      r_tens   <= w_tens;
      r_ones   <= w_ones;
      r_mode_d <= r_mode;
      wrap     <= w_wrap_evt;
      err      <= err | (r_cnt == 5'd31);
    end
  end

  // Scan FSM state and prescaler register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SCAN_ONES;
      r_presc <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
    end
  end

  // Scan next-state logic and output selection for the current digit
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc + 16'd1;
    w_dig_nxt   = 2'b00;
    w_seg_nxt   = 7'h00;
    w_dp_nxt    = 1'b0;
    if (r_presc == PRESC_TC) begin
      w_presc_nxt = 16'd0;
      w_state_nxt = (r_state == SCAN_ONES) ? SCAN_TENS : SCAN_ONES;
    end
    case (r_state)
      SCAN_ONES: begin
        w_dig_nxt = 2'b01;
        w_seg_nxt = seg_decode(r_ones);
        w_dp_nxt  = r_mode_d;
      end
      SCAN_TENS: begin
        if (r_tens != 4'd0) begin
          w_dig_nxt = 2'b10;
          w_seg_nxt = seg_decode(r_tens);
        end
      end
      default: ;
    endcase
  end

  // Stage 3: output register; polarity applied to seg/dp only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg    <= SEG_OFF;
      dp     <= DP_OFF;
      dig_en <= 2'b00;
    end else begin
      seg    <= w_seg_nxt ^ {7{SEG_ACTIVE_LOW}};
      dp     <= w_dp_nxt ^ SEG_ACTIVE_LOW;
      dig_en <= w_dig_nxt;
    end
  end

endmodule

// File: tb/tb_counter_seg_display.sv
// Bench for counter_seg_display: directed counter vectors, expectations
// queued per clock edge and checked by an independent monitor.
module tb_counter_seg_display;
  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] counter;
  logic       mode;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1, wrap0, wrap1, err0, err1;
  logic [1:0] dig0, dig1;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int rel0 = 0;
  bit err_seen = 1'b0;

  typedef struct {
    int         cyc;
    int         kind;   // 0 display, 1 wrap, 2 err
    logic [1:0] dig;
    logic [6:0] seg;
    logic       dp;
    logic       bitv;
    string      name;
  } exp_t;

  exp_t sb[$];

  counter_seg_display #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .rst(rst), .counter(counter), .mode(mode),
    .seg(seg0), .dp(dp0), .dig_en(dig0), .wrap(wrap0), .err(err0));

  counter_seg_display #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst(rst), .counter(counter), .mode(mode),
    .seg(seg1), .dp(dp1), .dig_en(dig1), .wrap(wrap1), .err(err1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] segtab(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  15: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [9:0] act, input logic [9:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %h expected %h", nm, cyc, act, expv);
    end
  endtask

  task automatic push_disp(input int e, input int v, input bit m, input string nm);
    exp_t x;
    int t, o;
    t = (v == 31) ? 15 : v / 10;
    o = (v == 31) ? 15 : v % 10;
    x.cyc = e; x.kind = 0; x.bitv = 1'b0; x.name = nm;
    if ((((e - rel0 - 1) / SD) % 2) == 0) begin
      x.dig = 2'b01; x.seg = segtab(o); x.dp = m;
    end else if (t == 0) begin
      x.dig = 2'b00; x.seg = 7'h00; x.dp = 1'b0;
    end else begin
      x.dig = 2'b10; x.seg = segtab(t); x.dp = 1'b0;
    end
    sb.push_back(x);
  endtask

  task automatic push_flag(input int e, input int k, input bit v, input string nm);
    exp_t x;
    x.cyc = e; x.kind = k; x.dig = 2'b00; x.seg = 7'h00; x.dp = 1'b0;
    x.bitv = v; x.name = nm;
    sb.push_back(x);
  endtask

  // counter value applied here is sampled at the next edge
  task automatic apply(input int v, input bit m);
    @(posedge clk);
    #1;
    counter = 5'(v);
    mode    = m;
  endtask

  task automatic hold(input int v, input bit m, input int n, input string nm);
    int n0;
    n0 = cyc + 1;
    for (int e = n0 + 3; e <= n0 + n + 2; e++) push_disp(e, v, m, nm);
    for (int e = n0 + 3; e <= n0 + n + 1; e++) begin
      push_flag(e, 1, 1'b0, {nm, " wrap"});
      push_flag(e, 2, err_seen, {nm, " err"});
    end
    for (int i = 0; i < n; i++) apply(v, m);
  endtask

  task automatic chk_reset(input string nm);
    cmp({nm, " out0"}, {dig0, seg0, dp0}, {2'b00, 7'h00, 1'b0});
    cmp({nm, " out1"}, {dig1, seg1, dp1}, {2'b00, 7'h7F, 1'b1});
    cmp({nm, " flags"}, {6'd0, wrap0, err0, wrap1, err1}, 10'd0);
  endtask

  // Monitor: on every falling edge, retire the expectations due this edge
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          case (sb[i].kind)
            0: begin
              cmp({sb[i].name, " disp0"}, {dig0, seg0, dp0}, {sb[i].dig, sb[i].seg, sb[i].dp});
              cmp({sb[i].name, " disp1"}, {dig1, seg1, dp1}, {sb[i].dig, ~sb[i].seg, ~sb[i].dp});
            end
            1: cmp(sb[i].name, {8'd0, wrap0, wrap1}, {8'd0, sb[i].bitv, sb[i].bitv});
            default: cmp(sb[i].name, {8'd0, err0, err1}, {8'd0, sb[i].bitv, sb[i].bitv});
          endcase
          sb.delete(i);
        end else if (sb[i].cyc < cyc) begin
          n_vec++;
          n_bad++;
          $display("FAIL %s: expectation for edge %0d never checked", sb[i].name, sb[i].cyc);
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    int nz;
    rst = 1'b0; counter = 5'd0; mode = 1'b0;
    #1 rst = 1'b1;
    #1 chk_reset("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rel0 = cyc;
    for (int e = rel0 + 1; e <= rel0 + 3; e++) push_disp(e, 0, 1'b0, "first phase");
    hold(0, 1'b0, 12, "const 0");
    hold(27, 1'b0, 10, "const 27");

    nz = cyc + 3;
    push_flag(nz + 1, 1, 1'b0, "up wrap pre");
    push_flag(nz + 2, 1, 1'b1, "up wrap pulse");
    push_flag(nz + 3, 1, 1'b0, "up wrap post");
    apply(29, 1'b0); apply(30, 1'b0); apply(0, 1'b0); apply(1, 1'b0);
    hold(1, 1'b0, 4, "const 1");

    nz = cyc + 2;
    push_flag(nz + 1, 1, 1'b0, "down wrap pre");
    push_flag(nz + 2, 1, 1'b1, "down wrap pulse");
    push_flag(nz + 3, 1, 1'b0, "down wrap post");
    apply(0, 1'b1); apply(30, 1'b1); apply(29, 1'b1);
    hold(29, 1'b1, 10, "down 29 dp");

    nz = cyc + 1;
    push_flag(nz + 1, 2, 1'b0, "err before");
    push_flag(nz + 2, 2, 1'b1, "err rise");
    push_flag(nz + 2, 1, 1'b0, "no wrap 31");
    push_disp(nz + 3, 31, 1'b0, "dash");
    apply(31, 1'b0);
    err_seen = 1'b1;
    hold(5, 1'b0, 10, "after 31");
    hold(12, 1'b1, 10, "dp 12");

    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset("async reset");
    err_seen = 1'b0;
    counter = 5'd30; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset("held reset");
    @(posedge clk);
    #1 rst = 1'b0;
    rel0 = cyc;
    push_disp(rel0 + 1, 0, 1'b0, "restart 0a");
    push_disp(rel0 + 2, 0, 1'b0, "restart 0b");
    for (int e = rel0 + 1; e <= rel0 + 3; e++) push_flag(e, 1, 1'b0, "no wrap first 30");
    hold(30, 1'b0, 6, "post-reset 30");

    nz = cyc + 1;
    push_flag(nz + 1, 1, 1'b0, "rst wrap pre");
    push_flag(nz + 2, 1, 1'b1, "rst wrap pulse");
    push_flag(nz + 3, 1, 1'b0, "rst wrap post");
    apply(0, 1'b0);
    hold(0, 1'b0, 8, "after wrap 0");

    repeat (6) @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: expectation for edge %0d left pending", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
